seq_div: RTL and testbench

Iterative radix-2 integer divider that executes the RV32M DIV/DIVU/REM/REMU operations. It is the responder to the divide-unit strobes from the ALU control decoder. `div_load` captures the operands and the operation, and `dact` starts the iteration. The block then returns the quotient or remainder with a one-cycle `done` pulse. It sits beside the multiplier in the execute stage, and its `result` feeds the ALU result mux.

---
 rtl/seq_div_if.sv | 24 ++
 rtl/seq_div.sv | 244 ++++++++++++++++++++++++
 tb/tb_seq_div.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_div_if.sv
// Handshake bundle between the ALU control decoder (master) and the iterative divider (slave).
interface seq_div_if #(
  parameter int W = 32
);
  logic         div_load;
  logic         dact;
  logic [2:0]   funct3;
  logic         div_res_sel;
  logic [W-1:0] lhs;
  logic [W-1:0] rhs;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  modport master (
    output div_load, dact, funct3, div_res_sel, lhs, rhs,
    input  busy, done, result
  );

  modport slave (
    input  div_load, dact, funct3, div_res_sel, lhs, rhs,
    output busy, done, result
  );
endinterface

// File: rtl/seq_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional result cache for repeated operand pairs: define SEQ_DIV_RESULT_CACHE_EN.
module seq_div #(
  parameter int W = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_div_if.slave  bus
);

  localparam int CW = $clog2(W);
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MIN_W  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(W-1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOADED = 3'd1,
    RUN    = 3'd2,
    FIX    = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic [W-1:0] neg_f(input logic [W-1:0] v);
    neg_f = (~v) + ONE_W;
  endfunction

  function automatic logic [W-1:0] mag_f(input logic [W-1:0] v, input logic sgn);
    mag_f = (sgn && v[W-1]) ? neg_f(v) : v;
  endfunction

  state_t        state_r;
  state_t        state_nx_s;

  logic [W-1:0]  lhs_r;
  logic [W-1:0]  rhs_r;
  logic          signed_r;
  logic          res_sel_r;

  logic [W-1:0]  quo_r;
  logic [W-1:0]  rem_r;
  logic [W-1:0]  dvs_r;
  logic [CW-1:0] cnt_r;

  logic          busy_r;
  logic          done_r;
  logic [W-1:0]  result_r;

  logic          capture_s;
  logic          start_s;
  logic          finish_s;
  logic          div_zero_s;
  logic          ovf_s;
  logic          hit_s;
  logic          neg_q_s;
  logic          neg_r_s;
  logic [W:0]    rem_sh_s;
  logic [W:0]    diff_s;
  logic [W-1:0]  fin_quo_s;
  logic [W-1:0]  fin_rem_s;

  assign div_zero_s = (rhs_r == {W{1'b0}});
  assign ovf_s      = signed_r && (lhs_r == MIN_W) && (rhs_r == {W{1'b1}});
  assign neg_q_s    = signed_r && (lhs_r[W-1] ^ rhs_r[W-1]);
  assign neg_r_s    = signed_r && lhs_r[W-1];

  // The W+1-bit trial keeps the shifted-out remainder bit so divisors near 2^W stay exact.
  assign rem_sh_s = {rem_r, quo_r[W-1]};
  assign diff_s   = rem_sh_s - {1'b0, dvs_r};

`ifdef SEQ_DIV_RESULT_CACHE_EN
  logic          c_valid_r;
  logic [W-1:0]  c_lhs_r;
  logic [W-1:0]  c_rhs_r;
  logic          c_signed_r;
  logic [W-1:0]  c_quo_r;
  logic [W-1:0]  c_rem_r;

  assign hit_s = c_valid_r && (c_lhs_r == lhs_r) && (c_rhs_r == rhs_r) &&
                 (c_signed_r == signed_r);

  // Cache of the most recent completed operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid_r  <= 1'b0;
      c_lhs_r    <= {W{1'b0}};
      c_rhs_r    <= {W{1'b0}};
      c_signed_r <= 1'b0;
      c_quo_r    <= {W{1'b0}};
      c_rem_r    <= {W{1'b0}};
    end else begin
      if (finish_s) begin
        c_valid_r  <= 1'b1;
        c_lhs_r    <= lhs_r;
        c_rhs_r    <= rhs_r;
        c_signed_r <= signed_r;
        c_quo_r    <= fin_quo_s;
        c_rem_r    <= fin_rem_s;
      end
    end
  end
`else
  assign hit_s = 1'b0;
`endif

  // Next-state decode and the capture/start/finish strobes.
  always_comb begin
    state_nx_s = state_r;
    capture_s  = 1'b0;
    start_s    = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.div_load) begin
          capture_s  = 1'b1;
          state_nx_s = LOADED;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOADED: begin
        if (bus.div_load) begin
          capture_s  = 1'b1;
          state_nx_s = LOADED;
        end else if (bus.dact) begin
          if (div_zero_s || ovf_s || hit_s) begin
            finish_s   = 1'b1;
            state_nx_s = DONE;
          end else begin
            start_s    = 1'b1;
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = LOADED;
        end
      end
      RUN: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nx_s = FIX;
        end else begin
          state_nx_s = RUN;
        end
      end
      FIX: begin
        finish_s   = 1'b1;
        state_nx_s = DONE;
      end
      DONE: begin
        if (bus.div_load) begin
          capture_s  = 1'b1;
          state_nx_s = LOADED;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Final quotient/remainder presented on the transition into DONE.
  always_comb begin
    fin_quo_s = quo_r;
    fin_rem_s = rem_r;
    if (state_r == FIX) begin
      fin_quo_s = neg_q_s ? neg_f(quo_r) : quo_r;
      fin_rem_s = neg_r_s ? neg_f(rem_r) : rem_r;
    end else if (div_zero_s) begin
      fin_quo_s = {W{1'b1}};
      fin_rem_s = lhs_r;
    end else if (ovf_s) begin
      fin_quo_s = lhs_r;
      fin_rem_s = {W{1'b0}};
`ifdef SEQ_DIV_RESULT_CACHE_EN
    end else if (hit_s) begin
      fin_quo_s = c_quo_r;
      fin_rem_s = c_rem_r;
`endif
    end else begin
      fin_quo_s = quo_r;
      fin_rem_s = rem_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhs_r     <= {W{1'b0}};
      rhs_r     <= {W{1'b0}};
      signed_r  <= 1'b0;
      res_sel_r <= 1'b0;
      quo_r     <= {W{1'b0}};
      rem_r     <= {W{1'b0}};
      dvs_r     <= {W{1'b0}};
      cnt_r     <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= {W{1'b0}};
    end else begin
      if (capture_s) begin
        lhs_r     <= bus.lhs;
        rhs_r     <= bus.rhs;
        signed_r  <= ~bus.funct3[0];
        res_sel_r <= bus.div_res_sel;
      end
      if (start_s) begin
        quo_r <= mag_f(lhs_r, signed_r);
        dvs_r <= mag_f(rhs_r, signed_r);
        rem_r <= {W{1'b0}};
        cnt_r <= CNT_LAST;
      end else if (state_r == RUN) begin
        if (!diff_s[W]) begin
          rem_r <= diff_s[W-1:0];
          quo_r <= {quo_r[W-2:0], 1'b1};
        end else begin
          rem_r <= rem_sh_s[W-1:0];
          quo_r <= {quo_r[W-2:0], 1'b0};
        end
        cnt_r <= cnt_r - CNT_ONE;
      end
      if (finish_s) begin
        result_r <= res_sel_r ? fin_rem_s : fin_quo_s;
      end
      done_r <= finish_s;
      busy_r <= (state_nx_s == RUN) || (state_nx_s == FIX);
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_seq_div.sv
// Directed table-driven bench for seq_div (W = 32), with hand sequences for reset abort and load/dact collision.
module tb_seq_div;

  logic clk;
  logic rst_n;

  seq_div_if #(.W(32)) bus ();

  seq_div #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef SEQ_DIV_RESULT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prev_res;
  bit          c_valid;
  logic [31:0] c_a;
  logic [31:0] c_b;
  logic        c_sgn;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: actual %h required %h", name, idx, act, exp);
    end
  endtask

  task automatic load_op(input logic [2:0] f3, input logic sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.div_load    = 1'b1;
    bus.funct3      = f3;
    bus.div_res_sel = sel;
    bus.lhs         = a;
    bus.rhs         = b;
  endtask

  // Fires dact on the currently captured operands and checks result, latency, busy and pulse shape.
  task automatic fire_check(input int idx, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
    int  k;
    int  bcnt;
    int  exp_lat;
    bit  unstable;
    bit  sgn;
    bit  special;
    sgn     = ~f3[0];
    special = (b == 32'h0000_0000) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (special) begin
      exp_lat = 1;
    end else if (CACHE_EN && c_valid && c_a == a && c_b == b && c_sgn == sgn) begin
      exp_lat = 1;
    end else begin
      exp_lat = 34;
    end
    @(negedge clk);
    bus.div_load = 1'b0;
    bus.dact     = 1'b1;
    @(negedge clk);
    bus.dact = 1'b0;
    k        = 1;
    bcnt     = 0;
    unstable = 1'b0;
    while (bus.done !== 1'b1 && k < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      if (bus.result !== prev_res) unstable = 1'b1;
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout[%0d]: no done within %0d cycles", idx, k);
    end
    check("result", idx, bus.result, exp);
    check("latency", idx, 32'(k), 32'(exp_lat));
    check("busy_cycles", idx, 32'(bcnt), (exp_lat == 1) ? 32'd0 : 32'd33);
    check("result_stable", idx, {31'd0, unstable}, 32'd0);
    @(negedge clk);
    check("done_pulse", idx, {31'd0, bus.done}, 32'd0);
    prev_res = exp;
    c_valid  = 1'b1;
    c_a      = a;
    c_b      = b;
    c_sgn    = sgn;
  endtask

  initial begin
    int cnt_d;
    int cnt_b;

    vecs[0]  = '{3'b101, 1'b0, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{3'b100, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[2]  = '{3'b110, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[3]  = '{3'b111, 1'b1, 32'd7,          32'd2,          32'd1};
    vecs[4]  = '{3'b101, 1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[5]  = '{3'b110, 1'b1, 32'd5,          32'd0,          32'd5};
    vecs[6]  = '{3'b100, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[7]  = '{3'b110, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[8]  = '{3'b100, 1'b0, 32'd1000,       32'd3,          32'd333};
    vecs[9]  = '{3'b110, 1'b1, 32'd1000,       32'd3,          32'd1};
    vecs[10] = '{3'b101, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[11] = '{3'b111, 1'b1, 32'hFFFF_FFFF,  32'd10,         32'd5};
    vecs[12] = '{3'b100, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[13] = '{3'b110, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1};
    vecs[14] = '{3'b101, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[15] = '{3'b111, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[16] = '{3'b100, 1'b0, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2};
    vecs[17] = '{3'b110, 1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE};

    clk             = 1'b0;
    rst_n           = 1'b0;
    bus.div_load    = 1'b0;
    bus.dact        = 1'b0;
    bus.funct3      = 3'b000;
    bus.div_res_sel = 1'b0;
    bus.lhs         = 32'd0;
    bus.rhs         = 32'd0;
    prev_res        = 32'd0;
    c_valid         = 1'b0;
    c_a             = 32'd0;
    c_b             = 32'd0;
    c_sgn           = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_busy", 0, {31'd0, bus.busy}, 32'd0);
    check("reset_done", 0, {31'd0, bus.done}, 32'd0);
    check("reset_result", 0, bus.result, 32'd0);
    rst_n = 1'b1;

    // dact with nothing loaded must be ignored.
    @(negedge clk);
    bus.dact = 1'b1;
    @(negedge clk);
    bus.dact = 1'b0;
    cnt_d = 0;
    repeat (5) begin
      if (bus.done === 1'b1) cnt_d++;
      @(negedge clk);
    end
    check("idle_dact_ignored", 0, 32'(cnt_d), 32'd0);

    for (int i = 0; i < NV; i++) begin
      load_op(vecs[i].f3, vecs[i].sel, vecs[i].a, vecs[i].b);
      fire_check(i, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // div_load and dact together in LOADED: the new operands win, dact is dropped.
    load_op(3'b101, 1'b0, 32'd100, 32'd7);
    @(negedge clk);
    bus.lhs  = 32'd1000;
    bus.rhs  = 32'd3;
    bus.dact = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    bus.dact     = 1'b0;
    cnt_d = 0;
    cnt_b = 0;
    repeat (4) begin
      if (bus.done === 1'b1) cnt_d++;
      if (bus.busy === 1'b1) cnt_b++;
      @(negedge clk);
    end
    check("collide_no_done", 100, 32'(cnt_d), 32'd0);
    check("collide_no_busy", 100, 32'(cnt_b), 32'd0);
    fire_check(100, 3'b101, 32'd1000, 32'd3, 32'd333);

    // Reset in RUN cycle 10 aborts everything.
    load_op(3'b101, 1'b0, 32'd100, 32'd7);
    @(negedge clk);
    bus.div_load = 1'b0;
    bus.dact     = 1'b1;
    @(negedge clk);
    bus.dact = 1'b0;
    repeat (9) @(negedge clk);
    check("run_busy", 200, {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 200, {31'd0, bus.busy}, 32'd0);
    check("abort_result", 200, bus.result, 32'd0);
    check("abort_done", 200, {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    prev_res = 32'd0;
    c_valid  = 1'b0;
    cnt_d = 0;
    cnt_b = 0;
    repeat (40) begin
      if (bus.done === 1'b1) cnt_d++;
      if (bus.busy === 1'b1) cnt_b++;
      @(negedge clk);
    end
    check("abort_no_done", 200, 32'(cnt_d), 32'd0);
    check("abort_no_busy", 200, 32'(cnt_b), 32'd0);
    bus.dact = 1'b1;
    @(negedge clk);
    bus.dact = 1'b0;
    cnt_d = 0;
    cnt_b = 0;
    repeat (40) begin
      if (bus.done === 1'b1) cnt_d++;
      if (bus.busy === 1'b1) cnt_b++;
      @(negedge clk);
    end
    check("post_reset_dact_done", 200, 32'(cnt_d), 32'd0);
    check("post_reset_dact_busy", 200, 32'(cnt_b), 32'd0);
    check("post_reset_result", 200, bus.result, 32'd0);

    // After reset the cache (if built) is empty: the first repeat pair needs the full iteration.
    load_op(3'b100, 1'b0, 32'd1000, 32'd3);
    fire_check(300, 3'b100, 32'd1000, 32'd3, 32'd333);
    load_op(3'b110, 1'b1, 32'd1000, 32'd3);
    fire_check(301, 3'b110, 32'd1000, 32'd3, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
